// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART ALU packet controller.
package uart_alu_pkg;

  localparam int unsigned HDR_BYTES = 4;
  localparam int unsigned LEN_W     = 16;

  typedef enum logic [7:0] {
    OP_ECHO = 8'hEC,
    OP_ADD  = 8'hA5,
    OP_MUL  = 8'h4C
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ECHO,
    OPERAND,
    RESULT,
    DRAIN
  } state_e;

endpackage

// File: rtl/uart_alu_word_asm.sv
// Little-endian byte-to-word shift assembler; word_valid_o flags the byte that
// completes a word, with word_o already including that byte.
module uart_alu_word_asm #(
  parameter int unsigned OPW = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  input  logic [7:0]     byte_i,
  input  logic           byte_valid_i,
  output logic [OPW-1:0] word_o,
  output logic           word_valid_o
);

  localparam int unsigned NB = OPW / 8;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

  logic [OPW-1:0] shift_q, shift_d;
  logic [IW-1:0]  cnt_q, cnt_d;
  logic           last_byte;

  assign last_byte    = (cnt_q == IW'(NB - 1));
  // New bytes enter at the top so the first byte ends up in the LSBs.
  assign word_o       = OPW'({byte_i, shift_q} >> 8);
  assign word_valid_o = byte_valid_i && !clr_i && last_byte;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid_i) begin
      shift_d = word_o;
      cnt_d   = last_byte ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_alu_pkt_ctrl.sv
// Packet controller between uart_rx and uart_tx: header parse, echo, add/reduce.
// Optional multiply opcode enabled by defining UART_ALU_MUL_EN.
module uart_alu_pkt_ctrl
  import uart_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OPW        = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned NB  = OPW / 8;
  localparam int unsigned IW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned HCW = $clog2(HDR_BYTES);
  localparam logic [LEN_W-1:0] NB_L = LEN_W'(NB);

  state_e           state_q, state_d;
  logic [HCW-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [7:0]       op_q, op_d;
  logic [7:0]       len_lo_q, len_lo_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [OPW-1:0]   acc_q, acc_d;
  logic             first_q, first_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             err_q, err_d;

  logic [LEN_W-1:0] len_full, pay_len;
  logic             is_alu;
  logic [OPW-1:0]   alu_word;
  logic [7:0]       res_byte;
  logic             asm_clr, asm_word_v;
  logic [OPW-1:0]   asm_word;

  assign len_full = {s_axis_tdata, len_lo_q};
  assign pay_len  = len_full - LEN_W'(HDR_BYTES);
  assign res_byte = 8'(acc_q >> {idx_q, 3'b000});

`ifdef UART_ALU_MUL_EN
  assign is_alu   = (op_q == OP_ADD) || (op_q == OP_MUL);
  assign alu_word = (op_q == OP_MUL) ? acc_q * asm_word : acc_q + asm_word;
`else
  assign is_alu   = (op_q == OP_ADD);
  assign alu_word = acc_q + asm_word;
`endif

  uart_alu_word_asm #(.OPW(OPW)) u_word_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (asm_clr),
    .byte_i       (s_axis_tdata),
    .byte_valid_i (s_axis_tvalid),
    .word_o       (asm_word),
    .word_valid_o (asm_word_v)
  );

  always_comb begin
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    op_d          = op_q;
    len_lo_d      = len_lo_q;
    rem_d         = rem_q;
    acc_d         = acc_q;
    first_d       = first_q;
    idx_d         = idx_q;
    err_d         = 1'b0;
    asm_clr       = 1'b1;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;

    case (state_q)
      IDLE, HDR: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          hdr_cnt_d = hdr_cnt_q + 1'b1;
          state_d   = HDR;
          if (hdr_cnt_q == '0) op_d = s_axis_tdata;
          if (hdr_cnt_q == HCW'(2)) len_lo_d = s_axis_tdata;
          if (hdr_cnt_q == HCW'(HDR_BYTES - 1)) begin
            hdr_cnt_d = '0;
            rem_d     = pay_len;
            first_d   = 1'b1;
            idx_d     = '0;
            if (len_full < LEN_W'(HDR_BYTES)) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else if (pay_len == '0) begin
              err_d   = (op_q != OP_ECHO);
              state_d = IDLE;
            end else if (op_q == OP_ECHO) begin
              state_d = ECHO;
            end else if (is_alu && ((pay_len % NB_L) == '0)) begin
              state_d = OPERAND;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end
        end
      end

      ECHO: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = IDLE;
        end
      end

      OPERAND: begin
        s_axis_tready = 1'b1;
        asm_clr       = 1'b0;
        if (s_axis_tvalid) begin
          rem_d = rem_q - 1'b1;
          if (asm_word_v) begin
            acc_d   = first_q ? asm_word : alu_word;
            first_d = 1'b0;
          end
          if (rem_q == LEN_W'(1)) state_d = RESULT;
        end
      end

      RESULT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = res_byte;
        if (m_axis_tready) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(NB - 1)) begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end

      DRAIN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs sit at their reset values for the whole time rst_i is high.
    if (rst_i) begin
      asm_clr       = 1'b1;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
    end
  end

  assign busy_o = !rst_i && (state_q != IDLE);
  assign err_o  = !rst_i && err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      hdr_cnt_q <= '0;
      op_q      <= '0;
      len_lo_q  <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      first_q   <= 1'b0;
      idx_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      op_q      <= op_d;
      len_lo_q  <= len_lo_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      first_q   <= first_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_alu_pkt_ctrl.sv
// Randomized self-checking bench for uart_alu_pkt_ctrl against a packet-level model.
module tb_uart_alu_pkt_ctrl;

`ifdef UART_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk_i;
  logic       rst_i;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       busy_o;
  logic       err_o;

  uart_alu_pkt_ctrl #(.DATA_WIDTH(8), .OPW(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] pkt_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int  exp_err;
  int  err_seen;
  int  cyc = 0;
  int  last_acc_cyc;
  int  first_valid_cyc;
  int  stab_bad = 0;
  int  rdy_bad  = 0;
  bit  alu_flag = 1'b0;
  bit  rnd_rdy  = 1'b0;
  bit  hold_rdy = 1'b0;
  bit  rnd_gap  = 1'b0;
  bit  stall_test = 1'b0;

  logic       prev_v  = 1'b0;
  logic       prev_hs = 1'b0;
  logic [7:0] prev_d  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (hold_rdy)     m_axis_tready = 1'b0;
      else if (rnd_rdy) m_axis_tready = ($urandom_range(0, 3) != 0);
      else              m_axis_tready = 1'b1;
    end
  end

  // Output monitor: handshakes seen here complete at the following rising edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
        if (err_o) err_seen++;
        if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_v && !prev_hs && !(m_axis_tvalid && m_axis_tdata == prev_d)) stab_bad++;
        if (alu_flag && m_axis_tvalid && s_axis_tready) rdy_bad++;
        prev_v  = m_axis_tvalid;
        prev_hs = m_axis_tvalid && m_axis_tready;
        prev_d  = m_axis_tdata;
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  // Packet-level reference: what the controller must emit for pkt_q.
  task automatic model_pkt();
    logic [7:0]  op;
    int          len, npay;
    logic [31:0] acc, w;
    exp_q.delete();
    exp_err = 0;
    acc = '0;
    op   = pkt_q[0];
    len  = int'({pkt_q[3], pkt_q[2]});
    npay = len - 4;
    if (len < 4) exp_err = 1;
    else if (npay == 0) exp_err = (op != 8'hEC) ? 1 : 0;
    else if (op == 8'hEC) begin
      for (int i = 0; i < npay; i++) exp_q.push_back(pkt_q[4 + i]);
    end else if ((op == 8'hA5 || (MUL_EN && op == 8'h4C)) && (npay % 4 == 0)) begin
      for (int wi = 0; wi < npay / 4; wi++) begin
        w = {pkt_q[4 + 4*wi + 3], pkt_q[4 + 4*wi + 2], pkt_q[4 + 4*wi + 1], pkt_q[4 + 4*wi]};
        if (wi == 0)          acc = w;
        else if (op == 8'hA5) acc = acc + w;
        else                  acc = acc * w;
      end
      for (int b = 0; b < 4; b++) exp_q.push_back(acc[8*b +: 8]);
    end else exp_err = 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    for (int k = 0; k < 2000 && !acc; k++) begin
      @(negedge clk_i);
      acc = s_axis_tready;
      @(posedge clk_i);
      #1;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    last_acc_cyc  = cyc;
    s_axis_tvalid = 1'b0;
    if (rnd_gap) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i);
        #1;
      end
    end
  endtask

  task automatic load(input logic [8*16-1:0] bytes, input int n);
    pkt_q.delete();
    for (int i = 0; i < n; i++) pkt_q.push_back(bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic run_pkt(input string name);
    bit idle;
    got_q.delete();
    err_seen        = 0;
    first_valid_cyc = -1;
    alu_flag        = (pkt_q[0] != 8'hEC);
    foreach (pkt_q[i]) send_byte(pkt_q[i]);
    if (stall_test) begin
      repeat (10) @(negedge clk_i);
      chk({name, "_stall_valid"}, 32'(m_axis_tvalid), 32'd1);
      chk({name, "_stall_data"}, 32'(m_axis_tdata), 32'h01);
      chk({name, "_stall_s_ready"}, 32'(s_axis_tready), 32'd0);
      hold_rdy = 1'b0;
    end
    idle = 1'b0;
    for (int k = 0; k < 500 && !idle; k++) begin
      @(negedge clk_i);
      idle = !busy_o;
    end
    if (!idle) chk({name, "_idle_timeout"}, 32'd0, 32'd1);
    repeat (3) @(posedge clk_i);
    #1;
    model_pkt();
    chk({name, "_busy_end"}, 32'(busy_o), 32'd0);
    chk({name, "_err_cnt"}, 32'(err_seen), 32'(exp_err));
    chk({name, "_out_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      chk({name, "_out_byte"}, (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
    if (alu_flag && exp_q.size() > 0)
      chk({name, "_latency"}, 32'(first_valid_cyc - last_acc_cyc), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_s_ready"}, 32'(s_axis_tready), 32'd0);
    chk({name, "_m_valid"}, 32'(m_axis_tvalid), 32'd0);
    chk({name, "_m_data"}, 32'(m_axis_tdata), 32'd0);
    chk({name, "_busy"}, 32'(busy_o), 32'd0);
    chk({name, "_err"}, 32'(err_o), 32'd0);
  endtask

  task automatic gen_random_pkt();
    int sel, r, len, op;
    sel = $urandom_range(0, 9);
    if (sel <= 3)      op = 8'hEC;
    else if (sel <= 6) op = 8'hA5;
    else if (sel <= 8) op = 8'h4C;
    else               op = $urandom_range(0, 255);
    r = $urandom_range(0, 9);
    if (r == 0)                len = $urandom_range(0, 4);
    else if (op == 8'hEC)      len = 5 + $urandom_range(0, 8);
    else if (r == 1)           len = 4 + 4 * $urandom_range(0, 3) + $urandom_range(1, 3);
    else                       len = 4 + 4 * $urandom_range(1, 4);
    pkt_q.delete();
    pkt_q.push_back(8'(op));
    pkt_q.push_back(8'($urandom_range(0, 255)));
    pkt_q.push_back(8'(len));
    pkt_q.push_back(8'(len >> 8));
    for (int i = 4; i < len; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    rst_i         = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_s_ready", 32'(s_axis_tready), 32'd1);
    @(posedge clk_i);
    #1;

    load(56'hEC000700414243, 7);                    run_pkt("echo");
    load(96'hA5000C00_01000000_02000000, 12);       run_pkt("add");
    hold_rdy   = 1'b1;
    stall_test = 1'b1;
    load(96'hA5000C00_FFFFFFFF_02000000, 12);       run_pkt("add_wrap");
    stall_test = 1'b0;
    load(48'h33000600AABB, 6);                      run_pkt("bad_op");
    load(56'hA5000700112233, 7);                    run_pkt("bad_len");
    load(40'hEC0005005A, 5);                        run_pkt("echo1");
    load(32'hEC000300, 4);                          run_pkt("len_lt4");
    load(32'hEC000400, 4);                          run_pkt("echo_len4");
    load(32'hA5000400, 4);                          run_pkt("add_len4");
    load(96'h4C000C00_03000000_05000000, 12);       run_pkt("mul");

    load(40'hA5000C0001, 5);
    foreach (pkt_q[i]) send_byte(pkt_q[i]);
    @(negedge clk_i);
    chk("mid_busy", 32'(busy_o), 32'd1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("mid_reset");
    @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("mid_reset_hold");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    load(64'hA5000800_07000000, 8);                 run_pkt("after_reset");

    rnd_rdy = 1'b1;
    rnd_gap = 1'b1;
    for (int p = 0; p < 40; p++) begin
      gen_random_pkt();
      run_pkt("rand");
    end

    chk("tdata_stable", 32'(stab_bad), 32'd0);
    chk("result_s_ready", 32'(rdy_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
